// File: rtl/sprite_pkg.sv
// -----------------------------------------------------------------------------
// sprite_pkg
// Shared constants and types for the sprite line prefetch scheduler.
//   SPR_SIZE / SPR_HALF : sprite edge length and half-length in pixels
//   state_t             : scheduler FSM states
//   PLANE/CHOPPER/BATTLESHIP : image select codes driven on rom_img
// -----------------------------------------------------------------------------
package sprite_pkg;

   localparam int unsigned SPR_SIZE = 32;
   localparam int unsigned SPR_HALF = 16;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      FETCH,
      DRAIN,
      DONE
   } state_t;

   localparam logic [4:0] PLANE      = 5'd0;
   localparam logic [4:0] CHOPPER    = 5'd1;
   localparam logic [4:0] BATTLESHIP = 5'd2;

endpackage

// File: rtl/sprite_row_check.sv
// -----------------------------------------------------------------------------
// sprite_row_check
// Combinational visibility test and sprite-row computation for one slot.
// Ports:
//   en   in  slot on-screen flag
//   line in  scanline being prefetched
//   y    in  sprite centre row
//   vis  out slot covers this scanline
//   row  out sprite row to fetch (line + 16 - y)
// -----------------------------------------------------------------------------
module sprite_row_check
   import sprite_pkg::*;
(
   input  logic       en,
   input  logic [9:0] line,
   input  logic [9:0] y,
   output logic       vis,
   output logic [4:0] row
);

   logic [10:0] line_lo;
   logic [10:0] y_hi;

   // Both sides widened to 11 bits so a sprite near the top of the screen
   // cannot produce a false hit from wrap-around at the bottom.
   always_comb begin
      line_lo = {1'b0, line} + 11'(SPR_HALF);
      y_hi    = {1'b0, y} + 11'(SPR_HALF);
      vis     = en && (line_lo >= {1'b0, y}) && ({1'b0, line} < y_hi);
      // Only the low five bits of the difference are meaningful when visible.
      row     = line[4:0] + 5'(SPR_HALF) - y[4:0];
   end

endmodule

// File: rtl/sprite_fetch_sched.sv
// -----------------------------------------------------------------------------
// sprite_fetch_sched
// Per-scanline sprite prefetch: during horizontal blank, walks every slot,
// clears the line buffer of off-line slots and copies one 32-pixel sprite row
// from the shared ROM into the line buffer of each visible slot.
// Optional feature: define SPRITE_FLIP_EN to add per-slot horizontal flip.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   line_start          pulse: begin a pass (restarts and flags overrun if busy)
//   next_line           scanline to prefetch, sampled on line_start
//   slot_en/_y/_img     per-slot enable, centre row, image select
//   slot_flip           per-slot horizontal flip (SPRITE_FLIP_EN only)
//   rom_addr, rom_img   shared ROM address (row*32+col) and image select
//   rom_data            ROM pixel, valid ROM_LAT cycles after rom_addr
//   lb_we/slot/idx/data line-buffer write port
//   lb_clr              clear whole line buffer of lb_slot
//   busy, done, overrun status: not idle, end-of-pass pulse, sticky overrun
// -----------------------------------------------------------------------------
module sprite_fetch_sched
   import sprite_pkg::*;
#(
   parameter int unsigned NUM_SLOTS = 3,
   parameter int unsigned ROM_LAT   = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   line_start,
   input  logic [9:0]             next_line,
   input  logic [NUM_SLOTS-1:0]   slot_en,
   input  logic [NUM_SLOTS*10-1:0] slot_y,
   input  logic [NUM_SLOTS*5-1:0] slot_img,
`ifdef SPRITE_FLIP_EN
   input  logic [NUM_SLOTS-1:0]   slot_flip,
`endif
   output logic [9:0]             rom_addr,
   output logic [4:0]             rom_img,
   input  logic [3:0]             rom_data,
   output logic                   lb_we,
   output logic [1:0]             lb_slot,
   output logic [4:0]             lb_idx,
   output logic [3:0]             lb_data,
   output logic                   lb_clr,
   output logic                   busy,
   output logic                   done,
   output logic                   overrun
);

   localparam logic [1:0]    LAST_SLOT  = 2'(NUM_SLOTS - 1);
   localparam int unsigned   DW         = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
   localparam logic [DW-1:0] DRAIN_LAST = DW'(ROM_LAT - 1);
   localparam logic [4:0]    COL_LAST   = 5'(SPR_SIZE - 1);

   state_t state_q, state_d;

   logic [9:0]         line_q;
   logic [1:0]         slot_q;
   logic [4:0]         row_q;
   logic [4:0]         img_q;
   logic [4:0]         col_q;
   logic [4:0]         col_eff;
   logic [DW-1:0]      drain_q;
   logic               overrun_q;
   logic [ROM_LAT-1:0] v_pipe;
   logic [4:0]         idx_pipe [ROM_LAT];

   logic               sel_en;
   logic [9:0]         sel_y;
   logic [4:0]         sel_img;
   logic               vis;
   logic [4:0]         row;
   logic               last;
   logic               fetch;

`ifdef SPRITE_FLIP_EN
   logic               sel_flip;
   logic               flip_q;
`endif

   // Current slot's inputs; only consumed while in CHECK.
   always_comb begin
      sel_en  = 1'b0;
      sel_y   = '0;
      sel_img = '0;
`ifdef SPRITE_FLIP_EN
      sel_flip = 1'b0;
`endif
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
         if (slot_q == 2'(i)) begin
            sel_en  = slot_en[i];
            sel_y   = slot_y[i*10 +: 10];
            sel_img = slot_img[i*5 +: 5];
`ifdef SPRITE_FLIP_EN
            sel_flip = slot_flip[i];
`endif
         end
      end
   end

   sprite_row_check u_row_check (
      .en   (sel_en),
      .line (line_q),
      .y    (sel_y),
      .vis  (vis),
      .row  (row)
   );

   assign last = (slot_q == LAST_SLOT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      busy    = 1'b1;
      done    = 1'b0;
      lb_clr  = 1'b0;
      fetch   = 1'b0;
      case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (line_start) state_d = CHECK;
         end
         CHECK: begin
            if (vis) begin
               state_d = FETCH;
            end else begin
               lb_clr  = 1'b1;
               state_d = last ? DONE : CHECK;
            end
         end
         FETCH: begin
            fetch = 1'b1;
            if (col_q == COL_LAST) state_d = DRAIN;
         end
         DRAIN: begin
            if (drain_q == DRAIN_LAST) state_d = last ? DONE : CHECK;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // A new line always restarts the pass from slot 0.
      if (line_start) state_d = CHECK;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         line_q    <= '0;
         slot_q    <= '0;
         row_q     <= '0;
         img_q     <= '0;
         col_q     <= '0;
         drain_q   <= '0;
         overrun_q <= 1'b0;
         v_pipe    <= '0;
         for (int unsigned i = 0; i < ROM_LAT; i++) idx_pipe[i] <= '0;
`ifdef SPRITE_FLIP_EN
         flip_q    <= 1'b0;
`endif
      end else begin
         v_pipe[0]   <= fetch;
         idx_pipe[0] <= col_q;
         for (int unsigned i = 1; i < ROM_LAT; i++) begin
            v_pipe[i]   <= v_pipe[i-1];
            idx_pipe[i] <= idx_pipe[i-1];
         end
         if (line_start) begin
            line_q <= next_line;
            slot_q <= '0;
            col_q  <= '0;
            // Drop in-flight writes so nothing from an aborted pass lands
            // after the restart.
            v_pipe <= '0;
            if (state_q != IDLE) overrun_q <= 1'b1;
         end else begin
            case (state_q)
               CHECK: begin
                  if (vis) begin
                     row_q <= row;
                     img_q <= sel_img;
                     col_q <= '0;
`ifdef SPRITE_FLIP_EN
                     flip_q <= sel_flip;
`endif
                  end else if (!last) begin
                     slot_q <= slot_q + 2'd1;
                  end
               end
               FETCH: begin
                  col_q   <= col_q + 5'd1;
                  drain_q <= '0;
               end
               DRAIN: begin
                  drain_q <= drain_q + DW'(1);
                  if (drain_q == DRAIN_LAST && !last) slot_q <= slot_q + 2'd1;
               end
               default: ;
            endcase
         end
      end
   end

`ifdef SPRITE_FLIP_EN
   assign col_eff = flip_q ? ~col_q : col_q;
`else
   assign col_eff = col_q;
`endif

   assign rom_addr = (state_q == FETCH) ? {row_q, col_eff} : '0;
   assign rom_img  = img_q;
   assign lb_we    = v_pipe[ROM_LAT-1];
   assign lb_idx   = lb_we ? idx_pipe[ROM_LAT-1] : '0;
   assign lb_data  = lb_we ? rom_data : '0;
   assign lb_slot  = slot_q;
   assign overrun  = overrun_q;

endmodule

// File: tb/tb_sprite_fetch_sched.sv
// -----------------------------------------------------------------------------
// tb_sprite_fetch_sched
// Scoreboard bench for sprite_fetch_sched: expected line-buffer writes and
// clears are queued when a line is started and consumed by a monitor.
// Define SPRITE_FLIP_EN to also exercise the flip option.
// -----------------------------------------------------------------------------
module tb_sprite_fetch_sched;

   localparam int unsigned NS  = 3;
   localparam int unsigned LAT = 1;

   logic              clk = 1'b0;
   logic              reset;
   logic              line_start;
   logic [9:0]        next_line;
   logic [NS-1:0]     slot_en;
   logic [NS*10-1:0]  slot_y;
   logic [NS*5-1:0]   slot_img;
`ifdef SPRITE_FLIP_EN
   logic [NS-1:0]     slot_flip;
`endif
   logic [9:0]        rom_addr;
   logic [4:0]        rom_img;
   logic [3:0]        rom_data;
   logic              lb_we;
   logic [1:0]        lb_slot;
   logic [4:0]        lb_idx;
   logic [3:0]        lb_data;
   logic              lb_clr;
   logic              busy;
   logic              done;
   logic              overrun;

   sprite_fetch_sched #(.NUM_SLOTS(NS), .ROM_LAT(LAT)) dut (
      .clk        (clk),
      .reset      (reset),
      .line_start (line_start),
      .next_line  (next_line),
      .slot_en    (slot_en),
      .slot_y     (slot_y),
      .slot_img   (slot_img),
`ifdef SPRITE_FLIP_EN
      .slot_flip  (slot_flip),
`endif
      .rom_addr   (rom_addr),
      .rom_img    (rom_img),
      .rom_data   (rom_data),
      .lb_we      (lb_we),
      .lb_slot    (lb_slot),
      .lb_idx     (lb_idx),
      .lb_data    (lb_data),
      .lb_clr     (lb_clr),
      .busy       (busy),
      .done       (done),
      .overrun    (overrun)
   );

   always #10 clk = ~clk;

   typedef struct {
      logic [1:0] slot;
      logic [4:0] idx;
      logic [3:0] data;
      logic [9:0] addr;
      logic [4:0] img;
   } wr_t;

   wr_t        exp_wr[$];
   logic [1:0] exp_clr[$];
   int         total = 0;
   int         bad = 0;
   int         exp_cycles = 0;

   function automatic logic [3:0] rom_f(input logic [9:0] a, input logic [4:0] img);
      return a[3:0] ^ a[7:4] ^ img[3:0] ^ {a[9:8], a[9:8]};
   endfunction

   // ROM model with fixed latency LAT.
   logic [3:0] rom_pipe [LAT];
   always @(posedge clk) begin
      rom_pipe[0] <= rom_f(rom_addr, rom_img);
      for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
   end
   assign rom_data = rom_pipe[LAT-1];

   // Monitor: addresses/images seen LAT cycles before each write.
   logic [9:0] ah [LAT];
   logic [4:0] ih [LAT];
   wr_t        e;
   logic [1:0] ec;
   always @(negedge clk) begin
      if (lb_we === 1'b1) begin
         total++;
         if (exp_wr.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write: actual slot=%0d idx=%0d required=no write", lb_slot, lb_idx);
         end else begin
            e = exp_wr.pop_front();
            if ({lb_slot, lb_idx, lb_data, ah[LAT-1], ih[LAT-1]} !== {e.slot, e.idx, e.data, e.addr, e.img}) begin
               bad++;
               $display("FAIL lb_write: actual slot=%0d idx=%0d data=%0d addr=%0d img=%0d required slot=%0d idx=%0d data=%0d addr=%0d img=%0d",
                        lb_slot, lb_idx, lb_data, ah[LAT-1], ih[LAT-1], e.slot, e.idx, e.data, e.addr, e.img);
            end
         end
      end
      if (lb_clr === 1'b1) begin
         total++;
         if (exp_clr.size() == 0) begin
            bad++;
            $display("FAIL unexpected_clr: actual slot=%0d required=no clear", lb_slot);
         end else begin
            ec = exp_clr.pop_front();
            if (lb_slot !== ec) begin
               bad++;
               $display("FAIL lb_clr_slot: actual=%0d required=%0d", lb_slot, ec);
            end
         end
      end
      for (int i = LAT - 1; i > 0; i--) begin
         ah[i] = ah[i-1];
         ih[i] = ih[i-1];
      end
      ah[0] = rom_addr;
      ih[0] = rom_img;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: actual=still running required=finished");
      $fatal(1, "watchdog");
   end

   task automatic set_slot(input int s, input logic en, input int y, input int img);
      slot_en[s]       = en;
      slot_y[s*10 +: 10] = 10'(y);
      slot_img[s*5 +: 5] = 5'(img);
   endtask

   // Reference model of one pass, built from the slot inputs at line start.
   task automatic push_expect(input int nl);
      int y, row, col;
      logic [4:0] img;
      logic flip;
      wr_t w;
      exp_cycles = 1;
      for (int s = 0; s < NS; s++) begin
         y    = int'(slot_y[s*10 +: 10]);
         img  = slot_img[s*5 +: 5];
         flip = 1'b0;
`ifdef SPRITE_FLIP_EN
         flip = slot_flip[s];
`endif
         if (slot_en[s] && (nl + 16 >= y) && (nl < y + 16)) begin
            row = nl + 16 - y;
            for (int c = 0; c < 32; c++) begin
               col    = flip ? 31 - c : c;
               w.slot = 2'(s);
               w.idx  = 5'(c);
               w.addr = 10'(row * 32 + col);
               w.img  = img;
               w.data = rom_f(w.addr, img);
               exp_wr.push_back(w);
            end
            exp_cycles += 33 + LAT;
         end else begin
            exp_clr.push_back(2'(s));
            exp_cycles += 1;
         end
      end
   endtask

   task automatic start_line(input int nl, input bit abort);
      @(posedge clk); #1;
      next_line  = 10'(nl);
      line_start = 1'b1;
      @(posedge clk); #1;
      line_start = 1'b0;
      if (abort) begin
         exp_wr.delete();
         exp_clr.delete();
      end
      push_expect(nl);
   endtask

   // 'already' = negedges consumed since start_line returned.
   task automatic wait_done(input string name, input bit no_fetch, input int already);
      int got = 0;
      bit addr_seen = 0;
      for (int n = already + 1; n <= 400; n++) begin
         @(negedge clk);
         if (rom_addr !== 10'd0) addr_seen = 1;
         if (done === 1'b1) begin
            got = n;
            break;
         end
      end
      total++;
      if (got != exp_cycles) begin
         bad++;
         $display("FAIL %s_done_cycle: actual=%0d required=%0d", name, got, exp_cycles);
      end
      @(negedge clk);
      total++;
      if ({done, busy} !== 2'b00) begin
         bad++;
         $display("FAIL %s_idle_after_done: actual done,busy=%b required=00", name, {done, busy});
      end
      total++;
      if (exp_wr.size() + exp_clr.size() != 0) begin
         bad++;
         $display("FAIL %s_drained: actual pending=%0d required=0", name, exp_wr.size() + exp_clr.size());
      end
      if (no_fetch) begin
         total++;
         if (addr_seen) begin
            bad++;
            $display("FAIL %s_no_rom_addr: actual=activity required=none", name);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; line_start = 1'b0; next_line = '0;
      slot_en = '0; slot_y = '0; slot_img = '0;
`ifdef SPRITE_FLIP_EN
      slot_flip = '0;
`endif
      repeat (3) @(negedge clk);
      total++;
      if ({busy, done, overrun, lb_we, lb_clr} !== 5'b0) begin
         bad++;
         $display("FAIL reset_ctrl: actual=%b required=00000", {busy, done, overrun, lb_we, lb_clr});
      end
      total++;
      if ({rom_addr, rom_img, lb_slot, lb_idx, lb_data} !== 26'b0) begin
         bad++;
         $display("FAIL reset_data: actual addr=%0d img=%0d slot=%0d idx=%0d data=%0d required=all 0",
                  rom_addr, rom_img, lb_slot, lb_idx, lb_data);
      end
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_single_slot();
      slot_en = '0;
      set_slot(0, 1'b1, 100, 1);
      start_line(90, 0);
      wait_done("single", 0, 0);
   endtask

   task automatic test_all_disabled();
      slot_en = '0;
      start_line(50, 0);
      wait_done("disabled", 1, 0);
   endtask

   task automatic test_boundary();
      int lines[5] = '{0, 20, 21, 1020, 1023};
      slot_en = '0;
      set_slot(0, 1'b1, 5, 2);
      for (int i = 0; i < 5; i++) begin
         if (i == 4) set_slot(0, 1'b1, 1015, 2);
         start_line(lines[i], 0);
         wait_done($sformatf("boundary%0d", lines[i]), 0, 0);
      end
   endtask

   task automatic test_multi_slot();
      set_slot(0, 1'b1, 200, 0);
      set_slot(1, 1'b1, 210, 2);
      set_slot(2, 1'b1, 195, 1);
      start_line(205, 0);
      wait_done("multi", 0, 0);
   endtask

   task automatic test_sample_hold();
      slot_en = '0;
      set_slot(0, 1'b1, 300, 2);
      start_line(300, 0);
      repeat (5) @(negedge clk);
      set_slot(0, 1'b0, 0, 5);
      wait_done("sample_hold", 0, 5);
   endtask

   task automatic test_overrun();
      set_slot(0, 1'b1, 400, 1);
      set_slot(1, 1'b1, 405, 2);
      set_slot(2, 1'b0, 0, 0);
      start_line(400, 0);
      repeat (45) @(negedge clk);
      total++;
      if (overrun !== 1'b0) begin
         bad++;
         $display("FAIL overrun_before: actual=%b required=0", overrun);
      end
      start_line(410, 1);
      @(negedge clk);
      total++;
      if (overrun !== 1'b1) begin
         bad++;
         $display("FAIL overrun_set: actual=%b required=1", overrun);
      end
      wait_done("overrun_restart", 0, 1);
      total++;
      if (overrun !== 1'b1) begin
         bad++;
         $display("FAIL overrun_sticky: actual=%b required=1", overrun);
      end
   endtask

   task automatic test_reset_mid_fetch();
      bit busy_seen = 0;
      slot_en = '0;
      set_slot(0, 1'b1, 500, 1);
      start_line(500, 0);
      repeat (10) @(negedge clk);
      #2;
      reset = 1'b1;
      exp_wr.delete();
      exp_clr.delete();
      #1;
      total++;
      if ({busy, lb_we, overrun} !== 3'b000) begin
         bad++;
         $display("FAIL reset_mid_fetch: actual busy,lb_we,overrun=%b required=000", {busy, lb_we, overrun});
      end
      total++;
      if (rom_addr !== 10'd0) begin
         bad++;
         $display("FAIL reset_mid_fetch_addr: actual=%0d required=0", rom_addr);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (busy !== 1'b0) busy_seen = 1;
      end
      total++;
      if (busy_seen) begin
         bad++;
         $display("FAIL reset_release_idle: actual=busy required=idle");
      end
   endtask

`ifdef SPRITE_FLIP_EN
   task automatic test_flip();
      slot_en   = '0;
      slot_flip = '0;
      set_slot(0, 1'b1, 100, 2);
      slot_flip[0] = 1'b1;
      start_line(84, 0);
      wait_done("flip", 0, 0);
      slot_flip = '0;
   endtask
`endif

   initial begin
      test_reset();
      test_single_slot();
      test_all_disabled();
      test_boundary();
      test_multi_slot();
      test_sample_hold();
      test_overrun();
      test_reset_mid_fetch();
`ifdef SPRITE_FLIP_EN
      test_flip();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
